sram_mem_ctrl: RTL and testbench

- Sequences the MEM stage's data-memory accesses onto an external 16-bit asynchronous SRAM with fixed wait states.
- Each 32-bit load/store is split into two halfword accesses: low half, then high half.
- Drives `ready` low while busy. The pipeline freezes every stage register, including the MEM/WB register, until `ready` returns high.
- Sits between the EXE/MEM register outputs and the MEM/WB register inputs. `rdata` feeds that register's memory-data input.

---
 rtl/mem_pkg.sv | 16 +
 rtl/sram_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-stage constants: controller state encoding, SRAM data
// width and the default SRAM address width / base address mapping.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam int          SRAM_DW       = 16;
    localparam int          SRAM_AW_DEF   = 18;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two fixed-wait halfword
// accesses (low, then high) on an external 16-bit asynchronous SRAM.
// Ports: clk, rst (sync, active-high); rd_en/wr_en/addr/wdata from EXE/MEM;
// rdata to MEM/WB; ready freezes the pipeline while low; sram_addr,
// sram_dq_o, sram_dq_oe, sram_we_n drive the SRAM; sram_dq_i returns data.
module sram_mem_ctrl
    import mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [SRAM_AW-1:0] base_q, base_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        rdata_d;
    logic [SRAM_AW-1:0] sram_addr_d;
    logic [SRAM_DW-1:0] dq_d;
    logic               oe_d;
    logic               we_n_d;
    logic               req;
    logic [SRAM_AW-1:0] half_base;

    assign req = rd_en | wr_en;

    // Word offset from the base, scaled to halfwords; wraps below the base.
    assign half_base = SRAM_AW'(((addr - BASE_ADDR) >> 2) << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            base_q     <= '0;
            wd_q       <= '0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            base_q     <= base_d;
            wd_q       <= wd_d;
            rdata      <= rdata_d;
            sram_addr  <= sram_addr_d;
            sram_dq_o  <= dq_d;
            sram_dq_oe <= oe_d;
            sram_we_n  <= we_n_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        base_d      = base_q;
        wd_d        = wd_q;
        rdata_d     = rdata;
        sram_addr_d = sram_addr;
        dq_d        = sram_dq_o;
        oe_d        = sram_dq_oe;
        we_n_d      = sram_we_n;
        ready       = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d     = LO;
                    cnt_d       = '0;
                    op_d        = wr_en;
                    base_d      = half_base;
                    wd_d        = wdata;
                    sram_addr_d = half_base;
                    dq_d        = wdata[15:0];
                    oe_d        = wr_en;
                    we_n_d      = ~wr_en;
                end
            end
            LO: begin
                if (cnt_q == LAST) begin
                    state_d     = HI;
                    cnt_d       = '0;
                    if (!op_q) begin
                        rdata_d[15:0] = sram_dq_i;
                    end
                    sram_addr_d = base_q + SRAM_AW'(1);
                    dq_d        = wd_q[31:16];
                    oe_d        = op_q;
                    we_n_d      = ~op_q;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    // Strobe released on the last cycle to hold data past WE rise.
                    we_n_d = ~(op_q && (cnt_q + 4'd1 != LAST));
                end
            end
            HI: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_q) begin
                        rdata_d[31:16] = sram_dq_i;
                    end
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    we_n_d = ~(op_q && (cnt_q + 4'd1 != LAST));
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
                oe_d    = 1'b0;
                we_n_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench: two controllers (3 and 2 wait states) each on a
// behavioural SRAM, driven from a vector table with a result scoreboard.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic [17:0] sram_addr [2];
    logic [15:0] sram_dq_o [2];
    logic [15:0] sram_dq_i [2];
    logic        sram_dq_oe [2];
    logic        sram_we_n [2];

    logic [15:0] mem0 [262144];
    logic [15:0] mem1 [262144];
    logic        pk_en [2];
    logic [17:0] pk_addr;
    logic [15:0] pk_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    sram_mem_ctrl #(.WAIT_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst[0]), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .ready(ready[0]), .sram_addr(sram_addr[0]),
        .sram_dq_o(sram_dq_o[0]), .sram_dq_i(sram_dq_i[0]),
        .sram_dq_oe(sram_dq_oe[0]), .sram_we_n(sram_we_n[0])
    );

    sram_mem_ctrl #(.WAIT_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst[1]), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .ready(ready[1]), .sram_addr(sram_addr[1]),
        .sram_dq_o(sram_dq_o[1]), .sram_dq_i(sram_dq_i[1]),
        .sram_dq_oe(sram_dq_oe[1]), .sram_we_n(sram_we_n[1])
    );

    // Behavioural SRAMs: asynchronous read, write while WE is low.
    assign sram_dq_i[0] = mem0[sram_addr[0]];
    assign sram_dq_i[1] = mem1[sram_addr[1]];

    always @(posedge clk) begin
        if (pk_en[0])
            mem0[pk_addr] <= pk_data;
        else if (!sram_we_n[0] && sram_dq_oe[0])
            mem0[sram_addr[0]] <= sram_dq_o[0];
    end

    always @(posedge clk) begin
        if (pk_en[1])
            mem1[pk_addr] <= pk_data;
        else if (!sram_we_n[1] && sram_dq_oe[1])
            mem1[sram_addr[1]] <= sram_dq_o[1];
    end

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic [17:0] exp_hb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input int i, input logic [17:0] a,
                        input logic [15:0] d);
        @(posedge clk); #1;
        pk_en[i] = 1'b1;
        pk_addr  = a;
        pk_data  = d;
        @(posedge clk); #1;
        pk_en[i] = 1'b0;
    endtask

    // One access from the cycle after the previous DONE (back-to-back).
    // Requests drop and addr/wdata are scrambled once the access is latched.
    task automatic access(input int i, input int w, input vec_t v);
        int lat = 0;
        int we_cnt = 0;
        int oe_cnt = 0;
        logic [31:0] e;
        bit is_wr;
        is_wr = v.wr;
        @(posedge clk); #1;
        rd_en[i] = v.rd;
        wr_en[i] = v.wr;
        addr[i]  = v.a;
        wdata[i] = v.d;
        sb_q.push_back(v.exp_rdata);
        #1;
        check("ready_drop", 32'(ready[i]), 32'd0);
        while (!ready[i] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                rd_en[i] = 1'b0;
                wr_en[i] = 1'b0;
                addr[i]  = $urandom;
                wdata[i] = $urandom;
                check("addr_lo", 32'(sram_addr[i]), 32'(v.exp_hb));
            end
            if (lat == w + 1)
                check("addr_hi", 32'(sram_addr[i]), 32'(v.exp_hb + 18'd1));
            if (!sram_we_n[i]) we_cnt++;
            if (sram_dq_oe[i]) oe_cnt++;
        end
        check("latency", 32'(lat), 32'(2 * w + 1));
        e = sb_q.pop_front();
        check("rdata", rdata[i], e);
        check("we_cycles", 32'(we_cnt), is_wr ? 32'(2 * (w - 1)) : 32'd0);
        check("oe_cycles", 32'(oe_cnt), is_wr ? 32'(2 * w) : 32'd0);
    endtask

    vec_t tbl [8];
    vec_t v;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]   = 1'b1;
            rd_en[i] = 1'b0;
            wr_en[i] = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
            pk_en[i] = 1'b0;
        end
        pk_addr = '0;
        pk_data = '0;

        tbl[0] = '{1, 0, 32'd1024, 32'h0,        32'hDEADBEEF, 18'd0};
        tbl[1] = '{0, 1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 18'd4};
        tbl[2] = '{1, 0, 32'd1032, 32'h0,        32'h12345678, 18'd4};
        tbl[3] = '{0, 1, 32'd1036, 32'hCAFEF00D, 32'h12345678, 18'd6};
        tbl[4] = '{1, 0, 32'd1036, 32'h0,        32'hCAFEF00D, 18'd6};
        tbl[5] = '{1, 0, 32'd1027, 32'h0,        32'hDEADBEEF, 18'd0};
        tbl[6] = '{1, 1, 32'd1040, 32'hA5A55A5A, 32'hDEADBEEF, 18'd8};
        tbl[7] = '{1, 0, 32'd1040, 32'h0,        32'hA5A55A5A, 18'd8};

        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(ready[i]), 32'd1);
            check("rst_we_n", 32'(sram_we_n[i]), 32'd1);
            check("rst_oe", 32'(sram_dq_oe[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_addr", 32'(sram_addr[i]), 32'd0);
            check("rst_dq_o", 32'(sram_dq_o[i]), 32'd0);
        end

        poke(0, 18'd0, 16'hBEEF);
        poke(0, 18'd1, 16'hDEAD);
        poke(1, 18'h3FFFE, 16'h1111);
        poke(1, 18'h3FFFF, 16'h2222);

        for (int k = 0; k < 8; k++)
            access(0, 3, tbl[k]);

        check("mem_h4", 32'(mem0[4]), 32'h5678);
        check("mem_h5", 32'(mem0[5]), 32'h1234);
        check("mem_h8", 32'(mem0[8]), 32'h5A5A);
        check("mem_h9", 32'(mem0[9]), 32'hA5A5);

        // Reset in the second HI cycle of a store.
        @(posedge clk); #1;
        wr_en[0] = 1'b1;
        addr[0]  = 32'd1048;
        wdata[0] = 32'h11112222;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) wr_en[0] = 1'b0;
        end
        check("mid_we_n", 32'(sram_we_n[0]), 32'd0);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        check("mid_rst_ready", 32'(ready[0]), 32'd1);
        check("mid_rst_we_n", 32'(sram_we_n[0]), 32'd1);
        check("mid_rst_oe", 32'(sram_dq_oe[0]), 32'd0);
        check("mid_rst_rdata", rdata[0], 32'd0);

        v = '{1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0};
        access(0, 3, v);

        // Two wait states, including an address below the base.
        v = '{1, 0, 32'd1020, 32'h0, 32'h22221111, 18'h3FFFE};
        access(1, 2, v);
        v = '{0, 1, 32'd1028, 32'h0BAD0F00, 32'h22221111, 18'd2};
        access(1, 2, v);
        v = '{1, 0, 32'd1028, 32'h0, 32'h0BAD0F00, 18'd2};
        access(1, 2, v);

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
